pwm_capture: RTL and testbench

Measures an incoming PWM waveform, such as the output of the team's PWM generator, and reports the high time and period of each complete cycle in clock cycles. It sits on the receive side of a PWM link for closed-loop checks, servo and fan feedback, and bench self-checking. A 2-flop synchronizer admits asynchronous inputs. A timeout flags inputs stuck at either level, for example 0 % or 100 % duty.

---
 rtl/pwm_capture.sv | 122 ++++++++++++
 tb/tb_pwm_capture.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an asynchronous PWM input and reports the high time and
// period of each complete cycle, with sticky timeout flags for an input stuck high or low.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwmin,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             ff1_q, ff1_d, ff2_q, ff2_d, pwm_d_q, pwm_d_d;
  logic             rise, fall;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_time_q, high_time_d, period_q, period_d;
  logic             valid_q, valid_d, stuck_high_q, stuck_high_d, stuck_low_q, stuck_low_d;

  // Sync chain resets high so an input already high at reset never looks like a rise.
  always_comb begin
    ff1_d   = pwmin;
    ff2_d   = ff1_q;
    pwm_d_d = ff2_q;
  end

  assign rise = ff2_q & ~pwm_d_q;
  assign fall = ~ff2_q & pwm_d_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_lat_d     = hi_lat_q;
    high_time_d  = high_time_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;
    unique case (state_q)
      SYNC: begin
        if (rise) begin
          cnt_d   = ONE;
          state_d = HIGH;
        end
      end
      HIGH: begin
        // An edge on the timeout cycle wins: a phase of exactly TIMEOUT is measured.
        if (fall) begin
          hi_lat_d = cnt_q;
          cnt_d    = cnt_q + ONE;
          state_d  = LOW;
        end else if (cnt_q == TO) begin
          stuck_high_d = 1'b1;
          state_d      = SYNC;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      LOW: begin
        if (rise) begin
          high_time_d  = hi_lat_q;
          period_d     = cnt_q;
          valid_d      = 1'b1;
          stuck_high_d = 1'b0;
          stuck_low_d  = 1'b0;
          cnt_d        = ONE;
          state_d      = HIGH;
        end else if (cnt_q == TO) begin
          stuck_low_d = 1'b1;
          state_d     = SYNC;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q        <= 1'b1;
      ff2_q        <= 1'b1;
      pwm_d_q      <= 1'b1;
      state_q      <= SYNC;
      cnt_q        <= '0;
      hi_lat_q     <= '0;
      high_time_q  <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      ff1_q        <= ff1_d;
      ff2_q        <= ff2_d;
      pwm_d_q      <= pwm_d_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_lat_q     <= hi_lat_d;
      high_time_q  <= high_time_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign high_time  = high_time_q;
  assign period     = period_q;
  assign valid      = valid_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: each driven PWM cycle queues its expected
// {high_time, period}, popped when the following rise produces valid.
module tb_pwm_capture;
  logic        clk = 1'b0;
  logic        rst, pwmin;
  logic [15:0] high_time, period;
  logic        valid, stuck_high, stuck_low;

  int          vectors = 0, miscompares = 0, valid_cnt = 0;
  logic [31:0] sb[$];
  logic [31:0] prev = '0, exp_v;
  logic        have_prev = 1'b0, valid_prev = 1'b0;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(16), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .pwmin(pwmin), .high_time(high_time), .period(period),
    .valid(valid), .stuck_high(stuck_high), .stuck_low(stuck_low)
  );

  // Scoreboard consumer
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid got ht=%0d per=%0d, none expected", high_time, period);
      end else begin
        exp_v = sb.pop_front();
        if ({high_time, period} !== exp_v) begin
          miscompares++;
          $display("FAIL measurement got ht=%0d per=%0d exp ht=%0d per=%0d",
                   high_time, period, exp_v[31:16], exp_v[15:0]);
        end
      end
      vectors++;
      if (valid_prev) begin
        miscompares++;
        $display("FAIL valid_width got 2+ cycle pulse exp 1 cycle");
      end
    end
    valid_prev = valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic level);
    pwmin = level;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    have_prev = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  // One PWM cycle of h high and l low clocks; queues the previous cycle's result.
  task automatic cyc(input int h, input int l);
    pwmin = 1'b1;
    if (have_prev) sb.push_back(prev);
    repeat (h) @(negedge clk);
    pwmin = 1'b0;
    repeat (l) @(negedge clk);
    prev      = {16'(h), 16'(h + l)};
    have_prev = 1'b1;
  endtask

  // Final rise closing the last driven cycle.
  task automatic finish_cycle();
    pwmin = 1'b1;
    if (have_prev) sb.push_back(prev);
    have_prev = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    pwmin = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({high_time, period, valid, stuck_high, stuck_low} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got ht=%0d per=%0d v=%b sh=%b sl=%b exp all 0",
               high_time, period, valid, stuck_high, stuck_low);
    end
    do_reset(1'b0);
    vectors++;
    if ({high_time, period, valid, stuck_high, stuck_low} !== 35'd0) begin
      miscompares++;
      $display("FAIL post_reset_outputs got ht=%0d per=%0d exp 0", high_time, period);
    end
  endtask

  task automatic test_basic();
    int v0;
    do_reset(1'b0);
    v0 = valid_cnt;
    repeat (5) cyc(10, 246);
    finish_cycle();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL basic_drain got %0d pending exp 0", sb.size());
    end
    vectors++;
    if (valid_cnt - v0 != 5) begin
      miscompares++;
      $display("FAIL basic_count got %0d valids exp 5", valid_cnt - v0);
    end
  endtask

  task automatic test_duty_change();
    int v0;
    do_reset(1'b0);
    v0 = valid_cnt;
    cyc(40, 216);
    cyc(50, 206);
    cyc(80, 176);
    cyc(90, 166);
    finish_cycle();
    vectors++;
    if (sb.size() != 0 || valid_cnt - v0 != 4) begin
      miscompares++;
      $display("FAIL duty_drain got pending=%0d valids=%0d exp 0 and 4", sb.size(), valid_cnt - v0);
    end
  endtask

  task automatic test_stuck_low();
    do_reset(1'b0);
    cyc(20, 236);
    cyc(20, 236);
    have_prev = 1'b0;
    // Timeout lands on the 1007th input-low clock, counting sync latency.
    repeat (770) @(negedge clk);
    vectors++;
    if (stuck_low !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_low_early got %b exp 0", stuck_low);
    end
    @(negedge clk);
    vectors++;
    if (stuck_low !== 1'b1 || stuck_high !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_low_set got sl=%b sh=%b exp 1 0", stuck_low, stuck_high);
    end
    vectors++;
    if (high_time !== 16'd20 || period !== 16'd256) begin
      miscompares++;
      $display("FAIL stuck_low_hold got ht=%0d per=%0d exp 20 256", high_time, period);
    end
    repeat (50) @(negedge clk);
    cyc(20, 236);
    vectors++;
    if (stuck_low !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck_low_sticky got %b exp 1", stuck_low);
    end
    cyc(20, 236);
    vectors++;
    if (stuck_low !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_low_clear got %b exp 0", stuck_low);
    end
    finish_cycle();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL stuck_low_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_stuck_high();
    int v0;
    do_reset(1'b1);
    v0 = valid_cnt;
    repeat (1100) @(negedge clk);
    vectors++;
    if (stuck_high !== 1'b0 || valid_cnt != v0 || period !== 16'd0) begin
      miscompares++;
      $display("FAIL high_at_reset got sh=%b valids=%0d per=%0d exp 0 0 0",
               stuck_high, valid_cnt - v0, period);
    end
    do_reset(1'b0);
    cyc(1024, 10);
    vectors++;
    if (stuck_high !== 1'b0) begin
      miscompares++;
      $display("FAIL exact_timeout_flag got %b exp 0", stuck_high);
    end
    cyc(5, 5);
    finish_cycle();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL exact_timeout_drain got %0d pending exp 0", sb.size());
    end
    do_reset(1'b0);
    cyc(1025, 5);
    have_prev = 1'b0;
    vectors++;
    if (stuck_high !== 1'b1 || stuck_low !== 1'b0) begin
      miscompares++;
      $display("FAIL over_timeout_flag got sh=%b sl=%b exp 1 0", stuck_high, stuck_low);
    end
    cyc(5, 5);
    cyc(5, 5);
    finish_cycle();
    vectors++;
    if (stuck_high !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL stuck_high_clear got sh=%b pending=%0d exp 0 0", stuck_high, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    do_reset(1'b0);
    cyc(10, 20);
    cyc(10, 20);
    cyc(10, 50);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({high_time, period, valid, stuck_high, stuck_low} !== 35'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got ht=%0d per=%0d v=%b exp 0", high_time, period, valid);
    end
    rst       = 1'b0;
    have_prev = 1'b0;
    repeat (10) @(negedge clk);
    v0 = valid_cnt;
    cyc(7, 13);
    vectors++;
    if (valid_cnt != v0) begin
      miscompares++;
      $display("FAIL mid_reset_first_rise got %0d valids exp 0", valid_cnt - v0);
    end
    cyc(7, 13);
    finish_cycle();
    vectors++;
    if (valid_cnt - v0 != 2 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset_count got %0d valids exp 2", valid_cnt - v0);
    end
  endtask

  task automatic test_extremes();
    int v0;
    do_reset(1'b0);
    v0 = valid_cnt;
    cyc(1, 4);
    pwmin = 1'b1;
    sb.push_back(prev);
    @(negedge clk);
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_edge1 got %b exp 0", valid);
    end
    pwmin = 1'b0;
    @(negedge clk);
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_edge2 got %b exp 0", valid);
    end
    pwmin = 1'b1;
    sb.push_back({16'd1, 16'd2});
    @(negedge clk);
    vectors++;
    if (valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_edge3 got %b exp 1", valid);
    end
    pwmin = 1'b0;
    @(negedge clk);
    prev      = {16'd1, 16'd2};
    have_prev = 1'b1;
    repeat (6) cyc(1, 1);
    finish_cycle();
    vectors++;
    if (valid_cnt - v0 != 9 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL square_count got %0d valids pending=%0d exp 9 0", valid_cnt - v0, sb.size());
    end
  endtask

  initial begin
    rst   = 1'b1;
    pwmin = 1'b0;
    test_reset();
    test_basic();
    test_duty_change();
    test_stuck_low();
    test_stuck_high();
    test_reset_mid();
    test_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
